// File: rtl/ysyx_22050550_dcache.sv
// ysyx_22050550_dcache
// Direct-mapped, write-through, no-write-allocate data cache between the LSU
// request port and an AXI4 master. Refills whole lines with an INCR burst;
// stores always go to memory as single-beat writes and finish on the B response.

module ysyx_22050550_dcache #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,

    // LSU side
    input  logic        io_Cache_valid,
    input  logic        io_Cache_op,
    input  logic [63:0] io_Cache_addr,
    input  logic [63:0] io_Cache_wdata,
    input  logic [7:0]  io_Cache_wmask,
    output logic [63:0] io_Cache_data,
    output logic        io_Cache_dataok,

    // AXI read address channel
    output logic        io_ar_valid,
    input  logic        io_ar_ready,
    output logic [63:0] io_ar_addr,
    output logic [7:0]  io_ar_len,
    output logic [2:0]  io_ar_size,
    output logic [1:0]  io_ar_burst,

    // AXI read data channel
    input  logic        io_r_valid,
    input  logic [63:0] io_r_rdata,
    input  logic        io_r_last,
    output logic        io_r_ready,

    // AXI write address channel
    output logic        io_aw_valid,
    input  logic        io_aw_ready,
    output logic [63:0] io_aw_addr,
    output logic [7:0]  io_aw_len,
    output logic [2:0]  io_aw_size,
    output logic [1:0]  io_aw_burst,

    // AXI write data channel
    output logic        io_w_valid,
    input  logic        io_w_ready,
    output logic [63:0] io_w_data,
    output logic [7:0]  io_w_strb,
    output logic        io_w_last,

    // AXI write response channel
    input  logic        io_b_valid,
    output logic        io_b_ready
);

    localparam int OFF_BITS  = $clog2(LINE_WORDS * 8);
    localparam int IDX_BITS  = $clog2(LINES);
    localparam int WSEL_BITS = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int TAG_BITS  = 32 - OFF_BITS - IDX_BITS;
    localparam int CNT_BITS  = WSEL_BITS + 1;

    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(LINE_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B,
        S_RESP
    } state_t;

    state_t state_q;
    state_t next_state;

    logic                req_op;
    logic [63:0]         req_addr;
    logic [63:0]         req_wdata;
    logic [7:0]          req_wmask;
    logic [CNT_BITS-1:0] beat_cnt;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [63:0]         data_q [LINES][LINE_WORDS];

    logic [IDX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic [WSEL_BITS-1:0] req_wsel;
    logic                 hit;
    logic [63:0]          rd_word;

    assign req_idx  = req_addr[OFF_BITS +: IDX_BITS];
    assign req_tag  = req_addr[OFF_BITS + IDX_BITS +: TAG_BITS];
    assign req_wsel = req_addr[3 +: WSEL_BITS];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign rd_word  = data_q[req_idx][req_wsel];

    // Burst shape fields never change
    assign io_ar_size  = 3'd3;
    assign io_ar_burst = 2'b01;
    assign io_aw_size  = 3'd3;
    assign io_aw_burst = 2'b01;
    assign io_w_last   = 1'b1;

    // State register, forced back to IDLE asynchronously by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state decode and state-driven outputs
    always_comb begin
        next_state      = state_q;
        io_Cache_data   = 64'd0;
        io_Cache_dataok = 1'b0;
        io_ar_valid     = 1'b0;
        io_ar_addr      = 64'd0;
        io_ar_len       = 8'd0;
        io_r_ready      = 1'b0;
        io_aw_valid     = 1'b0;
        io_aw_addr      = 64'd0;
        io_aw_len       = 8'd0;
        io_w_valid      = 1'b0;
        io_w_data       = 64'd0;
        io_w_strb       = 8'd0;
        io_b_ready      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (io_Cache_valid) begin
                    next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (req_op) begin
                    next_state = S_AW;
                end else if (hit) begin
                    next_state = S_RESP;
                end else begin
                    next_state = S_AR;
                end
            end
            S_AR: begin
                io_ar_valid = 1'b1;
                io_ar_addr  = {req_addr[63:OFF_BITS], {OFF_BITS{1'b0}}};
                io_ar_len   = 8'(LINE_WORDS - 1);
                if (io_ar_ready) begin
                    next_state = S_R;
                end
            end
            S_R: begin
                io_r_ready = 1'b1;
                if (io_r_valid && io_r_last) begin
                    next_state = S_RESP;
                end
            end
            S_AW: begin
                io_aw_valid = 1'b1;
                io_aw_addr  = {req_addr[63:3], 3'b000};
                if (io_aw_ready) begin
                    next_state = S_W;
                end
            end
            S_W: begin
                io_w_valid = 1'b1;
                io_w_data  = req_wdata;
                io_w_strb  = req_wmask;
                if (io_w_ready) begin
                    next_state = S_B;
                end
            end
            S_B: begin
                io_b_ready = 1'b1;
                if (io_b_valid) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                io_Cache_dataok = 1'b1;
                if (!req_op) begin
                    io_Cache_data = rd_word >> {req_addr[2:0], 3'b000};
                end
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Request latch, refill beat counter and line valid bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_op    <= 1'b0;
            req_addr  <= 64'd0;
            req_wdata <= 64'd0;
            req_wmask <= 8'd0;
            beat_cnt  <= '0;
            valid_q   <= '0;
        end else begin
            if (state_q == S_IDLE && io_Cache_valid) begin
                req_op    <= io_Cache_op;
                req_addr  <= io_Cache_addr;
                req_wdata <= io_Cache_wdata;
                req_wmask <= io_Cache_wmask;
            end
            if (state_q == S_AR && io_ar_ready) begin
                beat_cnt <= '0;
            end
            if (state_q == S_R && io_r_valid) begin
                if (beat_cnt < CNT_FULL) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
                if (io_r_last) begin
                    valid_q[req_idx] <= 1'b1;
                end
            end
        end
    end

    // Tag and data arrays: refill beats, tag on the last beat, store-hit merge
    always_ff @(posedge clock) begin
        if (state_q == S_R && io_r_valid) begin
            if (beat_cnt < CNT_FULL) begin
                data_q[req_idx][beat_cnt[WSEL_BITS-1:0]] <= io_r_rdata;
            end
            if (io_r_last) begin
                tag_q[req_idx] <= req_tag;
            end
        end
        if (state_q == S_LOOKUP && req_op && hit) begin
            for (int b = 0; b < 8; b++) begin
                if (req_wmask[b]) begin
                    data_q[req_idx][req_wsel][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: doc/ysyx_22050550_dcache.md
# ysyx_22050550_dcache

Direct-mapped, write-through, no-write-allocate data cache that sits directly downstream of the load/store unit. It serves the LSU `io_Cache_*` request port and fetches/writes physical memory (0x8xxxxxxx region) over an AXI4 master port. Reads return a byte-aligned 64-bit word that the LSU sign/zero-extends. Writes always go to memory and complete only after the B response.

## Interface
Parameters:
- `LINES`, 16: number of lines (power of 2).
- `LINE_WORDS`, 4: 64-bit words per line (power of 2). Default line is 32 B: offset = addr[4:0], index = addr[8:5], tag = addr[31:9].

Ports:
- `clock` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `io_Cache_valid` in 1: request present; held by LSU until the `dataok` cycle.
- `io_Cache_op` in 1: 0 = read, 1 = write.
- `io_Cache_addr` in 64: byte address.
- `io_Cache_wdata` in 64: write data, already placed on byte lanes.
- `io_Cache_wmask` in 8: byte-lane strobe.
- `io_Cache_data` out 64: read result, `word >> (addr[2:0]*8)`; 0 for writes.
- `io_Cache_dataok` out 1: one-cycle completion pulse.
- `io_ar_valid`/`io_ar_ready`/`io_ar_addr[63:0]`/`io_ar_len[7:0]`/`io_ar_size[2:0]`/`io_ar_burst[1:0]`: read address channel (out/in/out/out/out/out).
- `io_r_valid` in 1, `io_r_rdata` in 64, `io_r_last` in 1, `io_r_ready` out 1: read data channel.
- `io_aw_valid`/`io_aw_ready`/`io_aw_addr[63:0]`/`io_aw_len[7:0]`/`io_aw_size[2:0]`/`io_aw_burst[1:0]`: write address channel.
- `io_w_valid` out, `io_w_ready` in, `io_w_data` out 64, `io_w_strb` out 8, `io_w_last` out 1: write data channel.
- `io_b_valid` in 1, `io_b_ready` out 1: write response channel.

## Operation
- Storage is flop-based: `LINES` x (valid, tag, `LINE_WORDS` x 64-bit data). Reset clears every valid bit. Data and tag contents are don't-care after reset.
- States: IDLE, LOOKUP, AR, R, AW, W, B, RESP.
- IDLE: on `io_Cache_valid` = 1, latch op/addr/wdata/wmask and go to LOOKUP. Inputs are ignored in all other states.
- LOOKUP: hit = valid[index] && tag match.
  - Read hit -> RESP.
  - Read miss -> AR.
  - Write hit: merge wdata into the cached word under wmask in this cycle, then go to AW.
  - Write miss: go to AW with no allocation.
- AR: `ar_valid` = 1, `ar_addr` = line-aligned address, `ar_len` = `LINE_WORDS`-1, `ar_size` = 3, `ar_burst` = INCR (01). Fields are held stable until `ar_ready`, then go to R with beat counter = 0.
- R: `r_ready` = 1. Each `r_valid` beat writes word[counter], then counter++.
  - On `r_valid && r_last`: set valid and tag for the line, go to RESP.
  - `r_last` is authoritative. Beats beyond `LINE_WORDS` are accepted and discarded.
- AW: `aw_valid` = 1, `aw_addr` = {addr[63:3], 3'b0}, `aw_len` = 0, `aw_size` = 3, `aw_burst` = 01. Go to W on `aw_ready`.
- W: `w_valid` = 1, `w_data` = wdata, `w_strb` = wmask, `w_last` = 1. Go to B on `w_ready`.
- B: `b_ready` = 1. Go to RESP on `b_valid`. The BRESP code is not checked.
- RESP: `dataok` = 1 for exactly one cycle, then return to IDLE.
  - Reads: `io_Cache_data` = selected word shifted by addr[2:0]*8.
  - Writes: `io_Cache_data` = 0.
- AXI outputs not listed for a state are 0 in that state. `ar_size`/`ar_burst`/`aw_size`/`aw_burst`/`w_last` are constant.

## Timing
- Reset values: state = IDLE, `dataok` = 0, `io_Cache_data` = 0, all `*_valid`/`*_ready` outputs = 0, all valid bits = 0.
- Reset asserted mid-transaction: the FSM returns to IDLE asynchronously and any partially refilled line stays invalid.
- Read hit: request accepted in cycle 0, LOOKUP in cycle 1, `dataok` in cycle 2.
- Read miss: `ar_valid` first rises in cycle 2. `dataok` comes exactly 1 cycle after the `r_last` handshake.
- Write: `aw_valid` first rises in cycle 2. `dataok` comes exactly 1 cycle after the `b_valid` handshake.
- `dataok` is never asserted in LOOKUP. The LSU drops `valid` during the `dataok` cycle, so IDLE never re-accepts the completed request.
- Back-to-back: a new request may be accepted in the cycle after RESP.
- Valid/ready: each `*_valid` is asserted from registered state, independent of the matching ready, and is held until the handshake.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles mid-refill, then release. Required: all outputs 0; the next read of 0x80000000 misses (`ar_valid` in cycle 2).
- Read miss/hit: LD 0x80000008; slave returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with `r_last` on beat 4.
  - Required: `ar_addr` = 0x80000000, `ar_len` = 3, `dataok` 1 cycle after the last beat with data 0x2222222222222222.
  - Repeat the same read: `dataok` in cycle 2 and no `ar_valid`.
- Byte shift: word0 = 0x8877665544332211, read 0x80000003 -> `data[7:0]` = 0x44.
- Write hit: addr 0x80000000, wmask 0x0C, wdata 0x00000000AABB0000, `b_valid` delayed 4 cycles.
  - Required: `aw_addr` = 0x80000000, `w_strb` = 0x0C, `w_last` = 1, `dataok` 1 cycle after B.
  - Read 0x80000000 afterwards: hit with 0x88776655AABB2211.
- Write miss / no-allocate: write 0x80000400, then read 0x80000400 -> the read misses (`ar_valid` asserted).
- Conflict and backpressure: read 0x80000000, then 0x80000200 (same index 0) -> miss. Then 0x80000000 misses again with `ar_ready` low for 5 cycles; `ar_valid` and `ar_addr` are held stable throughout.
